// File: rtl/sm3_pkg.sv
// Shared SM3 constants, word type and rotate helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sm3_pkg;

    localparam int unsigned SM3_W     = 32;
    localparam int unsigned SM3_J_W   = 7;
    localparam int unsigned SM3_J_MAX = 63;
    // Rounds below this index use T0, the rest use T1.
    localparam int unsigned SM3_J_T1  = 16;

    typedef logic [SM3_W-1:0] sm3_word_t;

    localparam sm3_word_t SM3_T0 = 32'h79CC4519;
    localparam sm3_word_t SM3_T1 = 32'h7A879D8A;

    // 32-bit left rotate; amounts are taken modulo the word width.
    function automatic sm3_word_t rotl(input sm3_word_t w, input int unsigned amt);
        int unsigned s;
        s = amt % SM3_W;
        if (s == 0) begin
            return w;
        end
        return (w << s) | (w >> (SM3_W - s));
    endfunction

endpackage

// File: rtl/sm3_tj_gen.sv
// SM3 round constant generator: tj_rot = Tj <<< (j mod WIDTH), Tj = T0 for j<16 else T1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows j.
// Ports: j (round index), tj_rot (rotated round constant).
module sm3_tj_gen
    import sm3_pkg::*;
#(
    parameter int unsigned           WIDTH = SM3_W,
    parameter logic [WIDTH-1:0]      T0    = WIDTH'(SM3_T0),
    parameter logic [WIDTH-1:0]      T1    = WIDTH'(SM3_T1)
) (
    input  logic [SM3_J_W-1:0] j,
    output logic [WIDTH-1:0]   tj_rot
);

    // Width-generic rotate so the block can be reused with non-32-bit words.
    function automatic logic [WIDTH-1:0] rotw(input logic [WIDTH-1:0] x, input int unsigned s);
        if (s == 0) begin
            return x;
        end
        return (x << s) | (x >> (WIDTH - s));
    endfunction

    int unsigned      amt;
    logic [WIDTH-1:0] tj;

    always_comb begin
        amt    = 32'(j) % WIDTH;
        tj     = (32'(j) < SM3_J_T1) ? T0 : T1;
        tj_rot = rotw(tj, amt);
    end

endmodule

// File: rtl/sm3_ss_pipe.sv
// SM3 round helper: computes SS1 and SS2 from A, E and round index j, with tag passthrough.
// Latency: 2 cycles from accept to out_valid without backpressure; 1 result per cycle.
// Backpressure: valid/ready; in_ready = !s1_valid | s2_load, outputs held while out_ready=0.
// Ports: in_valid/in_ready/in_a/in_e/in_j/in_tag request side;
//        out_valid/out_ready/out_ss1/out_ss2/out_tag/out_err result side; clk, rst (async, high).
module sm3_ss_pipe
    import sm3_pkg::*;
#(
    parameter int unsigned           WIDTH   = SM3_W,
    parameter int unsigned           ROT_A   = 12,
    parameter int unsigned           ROT_SS1 = 7,
    parameter logic [WIDTH-1:0]      T0      = WIDTH'(SM3_T0),
    parameter logic [WIDTH-1:0]      T1      = WIDTH'(SM3_T1),
    parameter int unsigned           TAG_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_e,
    input  logic [SM3_J_W-1:0]    in_j,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_ss1,
    output logic [WIDTH-1:0]      out_ss2,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_err
);

    function automatic logic [WIDTH-1:0] rotw(input logic [WIDTH-1:0] x, input int unsigned s);
        if (s == 0) begin
            return x;
        end
        return (x << s) | (x >> (WIDTH - s));
    endfunction

    // ---------------------------------------------------------------
    // Pipeline control
    // ---------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_load;
    logic s1_load;

    // S2 can take new data when empty or when its current result leaves this cycle.
    assign s2_load   = !s2_valid || out_ready;
    // S1 frees up when empty or when it moves into S2; this is the only
    // combinational path from out_ready, and nothing flows from in_valid to out_*.
    assign in_ready  = !s1_valid || s2_load;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: rotate A, fetch rotated Tj, three-way sum
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] in_arot;
    logic [WIDTH-1:0] in_trot;
    logic [WIDTH-1:0] in_sum;
    logic             in_err;

    sm3_tj_gen #(
        .WIDTH (WIDTH),
        .T0    (T0),
        .T1    (T1)
    ) u_tj_gen (
        .j      (in_j),
        .tj_rot (in_trot)
    );

    assign in_arot = rotw(in_a, ROT_A);
    // Carries out of the word are dropped: addition is modulo 2^WIDTH.
    assign in_sum  = in_arot + in_e + in_trot;
    assign in_err  = (32'(in_j) > SM3_J_MAX);

    logic [WIDTH-1:0] s1_arot;
    logic [WIDTH-1:0] s1_sum;
    logic             s1_err;
    logic [TAG_W-1:0] s1_tag;

    // Stage-1 data needs no reset: it is only observed behind s1_valid.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_arot <= in_arot;
            s1_sum  <= in_sum;
            s1_err  <= in_err;
            s1_tag  <= in_tag;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: final rotate, XOR with rotated A, error squash
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] ss1_nxt;
    logic [WIDTH-1:0] ss2_nxt;

    always_comb begin
        ss1_nxt = '0;
        ss2_nxt = '0;
        if (!s1_err) begin
            ss1_nxt = rotw(s1_sum, ROT_SS1);
            ss2_nxt = ss1_nxt ^ s1_arot;
        end
    end

    // Only load on a real S1 entry so a held result is never disturbed by bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ss1 <= '0;
            out_ss2 <= '0;
            out_tag <= '0;
            out_err <= 1'b0;
        end else if (s2_load && s1_valid) begin
            out_ss1 <= ss1_nxt;
            out_ss2 <= ss2_nxt;
            out_tag <= s1_tag;
            out_err <= s1_err;
        end
    end

endmodule
